// File: rtl/debug_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_pkg
// Description : Shared FSM encoding, SYNC default and sizing helpers for the
//               debug snapshot frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_frame_pkg;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SYNC      = 3'd1;
    localparam logic [2:0] c_ST_COUNT     = 3'd2;
    localparam logic [2:0] c_ST_CH_ID     = 3'd3;
    localparam logic [2:0] c_ST_CH_DATA   = 3'd4;
    localparam logic [2:0] c_ST_CSUM      = 3'd5;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd6;

    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

    // Bytes needed to carry one channel (ceiling division by 8)
    function automatic int f_bpc(input int nb_ch);
        return (nb_ch + 7) / 8;
    endfunction

    function automatic int f_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : debug_byte_mux
// Description : Selects one byte (channel, byte index) from a latched
//               snapshot; bits above the channel width read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_byte_mux
    import debug_frame_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int NB_CH   = 32,
    parameter int NB_DATA = 8
) (
    input  logic [N_CH*NB_CH-1:0]                  i_snapshot,
    input  logic [f_cnt_width(N_CH)-1:0]           i_ch,
    input  logic [f_cnt_width(f_bpc(NB_CH))-1:0]   i_byte_idx,
    output logic [NB_DATA-1:0]                     o_byte
);

    localparam int c_bpc = f_bpc(NB_CH);
    localparam int c_cw  = f_cnt_width(N_CH);
    localparam int c_bw  = f_cnt_width(c_bpc);

    logic [NB_CH-1:0]           w_chan;
    logic [c_bpc*NB_DATA-1:0]   w_padded;

    always_comb begin
        w_chan = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_ch == c_cw'(k)) begin
                w_chan = i_snapshot[k*NB_CH +: NB_CH];
            end
        end
        w_padded              = '0;
        w_padded[NB_CH-1:0]   = w_chan;
        o_byte                = '0;
        for (int b = 0; b < c_bpc; b++) begin
            if (i_byte_idx == c_bw'(b)) begin
                o_byte = w_padded[b*NB_DATA +: NB_DATA];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_tx
// Description : Captures a masked set of snapshot channels on trigger and
//               streams them as a SYNC/COUNT/ID/DATA/CSUM byte frame to a UART.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_tx
    import debug_frame_pkg::*;
#(
    parameter int                 N_CH    = 4,
    parameter int                 NB_CH   = 32,
    parameter int                 NB_DATA = 8,
    parameter logic [NB_DATA-1:0] SYNC    = c_SYNC_DEFAULT,
    parameter int                 CSUM_EN = 1
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_trigger,
    input  logic [N_CH-1:0]         i_ch_mask,
    input  logic [N_CH*NB_CH-1:0]   i_snapshot,
    input  logic                    i_txDone,
    output logic                    o_tx_start,
    output logic [NB_DATA-1:0]      o_data,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int              c_bpc       = f_bpc(NB_CH);
    localparam int              c_cw        = f_cnt_width(N_CH);
    localparam int              c_bw        = f_cnt_width(c_bpc);
    localparam logic [c_bw-1:0] c_last_byte = c_bw'(c_bpc - 1);

    logic [2:0]               r_state;
    logic [2:0]               r_prev;
    logic [NB_DATA-1:0]       r_data;
    logic [NB_DATA-1:0]       r_csum;
    logic                     r_busy;
    logic                     r_done;
    logic [N_CH-1:0]          r_mask;
    logic [N_CH*NB_CH-1:0]    r_snap;
    logic [c_cw-1:0]          r_ch;
    logic [c_bw-1:0]          r_byte;

    logic [NB_DATA-1:0]       w_count;
    int                       w_from;
    logic                     w_found;
    logic [c_cw-1:0]          w_found_ch;
    logic [c_bw-1:0]          w_mux_byte;
    logic [NB_DATA-1:0]       w_mux_out;
    logic                     w_to_channel;
    logic [2:0]               w_next_state;
    logic [NB_DATA-1:0]       w_next_data;
    logic [c_cw-1:0]          w_next_ch;
    logic [c_bw-1:0]          w_next_byte;

    always_comb begin
        w_count = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_count = w_count + NB_DATA'(r_mask[k]);
        end
    end

    // Next selected channel: from 0 after COUNT, otherwise past the current one
    always_comb begin
        w_from     = (r_prev == c_ST_COUNT) ? 0 : int'(r_ch) + 1;
        w_found    = 1'b0;
        w_found_ch = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && (k >= w_from) && r_mask[k]) begin
                w_found    = 1'b1;
                w_found_ch = c_cw'(k);
            end
        end
    end

    assign w_mux_byte = (r_prev == c_ST_CH_DATA) ? r_byte + c_bw'(1) : '0;

    debug_byte_mux #(
        .N_CH    (N_CH),
        .NB_CH   (NB_CH),
        .NB_DATA (NB_DATA)
    ) u_byte_mux (
        .i_snapshot (r_snap),
        .i_ch       (r_ch),
        .i_byte_idx (w_mux_byte),
        .o_byte     (w_mux_out)
    );

    // Which byte follows the one just acknowledged (IDLE means frame complete)
    always_comb begin
        w_next_state = c_ST_IDLE;
        w_next_data  = '0;
        w_next_ch    = r_ch;
        w_next_byte  = '0;
        w_to_channel = 1'b0;
        case (r_prev)
            c_ST_SYNC: begin
                w_next_state = c_ST_COUNT;
                w_next_data  = w_count;
            end
            c_ST_COUNT: w_to_channel = 1'b1;
            c_ST_CH_ID: begin
                w_next_state = c_ST_CH_DATA;
                w_next_data  = w_mux_out;
            end
            c_ST_CH_DATA: begin
                if (r_byte != c_last_byte) begin
                    w_next_state = c_ST_CH_DATA;
                    w_next_data  = w_mux_out;
                    w_next_byte  = w_mux_byte;
                end else begin
                    w_to_channel = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_to_channel) begin
            if (w_found) begin
                w_next_state = c_ST_CH_ID;
                w_next_data  = NB_DATA'(w_found_ch);
                w_next_ch    = w_found_ch;
            end else if (CSUM_EN != 0) begin
                w_next_state = c_ST_CSUM;
                w_next_data  = r_csum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= c_ST_IDLE;
            r_prev  <= c_ST_IDLE;
            r_data  <= '0;
            r_csum  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mask  <= '0;
            r_snap  <= '0;
            r_ch    <= '0;
            r_byte  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_trigger) begin
                        r_snap  <= i_snapshot;
                        r_mask  <= i_ch_mask;
                        r_data  <= SYNC;
                        r_csum  <= SYNC;
                        r_busy  <= 1'b1;
                        r_ch    <= '0;
                        r_byte  <= '0;
                        r_state <= c_ST_SYNC;
                    end
                end
                c_ST_SYNC, c_ST_COUNT, c_ST_CH_ID, c_ST_CH_DATA, c_ST_CSUM: begin
                    r_prev  <= r_state;
                    r_state <= c_ST_WAIT_DONE;
                end
                c_ST_WAIT_DONE: begin
                    if (i_txDone) begin
                        if (w_next_state == c_ST_IDLE) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= w_next_state;
                            r_data  <= w_next_data;
                            r_csum  <= r_csum ^ w_next_data;
                            r_ch    <= w_next_ch;
                            r_byte  <= w_next_byte;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Each byte-issue state lasts exactly one cycle, giving the start pulse
    assign o_tx_start = (r_state == c_ST_SYNC)  || (r_state == c_ST_COUNT) ||
                        (r_state == c_ST_CH_ID) || (r_state == c_ST_CH_DATA) ||
                        (r_state == c_ST_CSUM);
    assign o_data     = r_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_debug_frame_tx.sv
`default_nettype none
// Testbench for debug_frame_tx: table vectors, hand sequences and random frames
// against a byte-list reference model, on a 4x12 (checksum) and 1x32 (no checksum) build.
module tb_debug_frame_tx;

    logic        clk = 1'b0;
    logic        rst, trig, txd, sel;
    logic [3:0]  mask;
    logic [47:0] snap;

    logic        a_tx_start, a_busy, a_done, b_tx_start, b_busy, b_done;
    logic [7:0]  a_data, b_data;
    logic        tx_start, busy, done;
    logic [7:0]  data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0]   mask;
        logic [47:0]  snap;
        int           len;
        logic [119:0] exp;
    } vec_t;
    vec_t vt[4];

    always #5 clk = ~clk;

    debug_frame_tx #(.N_CH(4), .NB_CH(12), .NB_DATA(8), .SYNC(8'hA5), .CSUM_EN(1)) dut_a (
        .clk(clk), .i_reset(rst), .i_trigger(trig & ~sel), .i_ch_mask(mask),
        .i_snapshot(snap), .i_txDone(txd & ~sel),
        .o_tx_start(a_tx_start), .o_data(a_data), .o_busy(a_busy), .o_done(a_done));

    debug_frame_tx #(.N_CH(1), .NB_CH(32), .NB_DATA(8), .SYNC(8'hA5), .CSUM_EN(0)) dut_b (
        .clk(clk), .i_reset(rst), .i_trigger(trig & sel), .i_ch_mask(mask[0]),
        .i_snapshot(snap[31:0]), .i_txDone(txd & sel),
        .o_tx_start(b_tx_start), .o_data(b_data), .o_busy(b_busy), .o_done(b_done));

    assign tx_start = sel ? b_tx_start : a_tx_start;
    assign data     = sel ? b_data     : a_data;
    assign busy     = sel ? b_busy     : a_busy;
    assign done     = sel ? b_done     : a_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    // Reference model: frame as a byte list straight from the framing rules
    function automatic void build_exp(input bit b, input logic [3:0] m, input logic [47:0] s);
        int         nch  = b ? 1 : 4;
        int         nbch = b ? 32 : 12;
        int         bpc  = (nbch + 7) / 8;
        int         cnt  = 0;
        logic [63:0] v;
        logic [7:0]  cs  = 8'h00;
        exp_q.delete();
        for (int k = 0; k < nch; k++) cnt += int'(m[k]);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(cnt));
        for (int k = 0; k < nch; k++) begin
            if (m[k]) begin
                exp_q.push_back(8'(k));
                v = (64'(s) >> (k * nbch)) & ((64'd1 << nbch) - 64'd1);
                for (int j = 0; j < bpc; j++) exp_q.push_back(v[j*8 +: 8]);
            end
        end
        if (!b) begin
            foreach (exp_q[i]) cs ^= exp_q[i];
            exp_q.push_back(cs);
        end
    endfunction

    function automatic void load_vec(input int i);
        logic [119:0] e = vt[i].exp;
        exp_q.delete();
        for (int j = 0; j < vt[i].len; j++) exp_q.push_back(e[(vt[i].len-1-j)*8 +: 8]);
    endfunction

    function automatic int pick_delay(input bit long_mode);
        if (long_mode && ($urandom_range(0, 4) == 0)) return int'($urandom_range(1, 1000));
        return int'($urandom_range(1, long_mode ? 6 : 3));
    endfunction

    // Drives one frame cycle by cycle and checks every cycle against exp_q
    task automatic run_frame(input string name, input bit pre_trig, input logic [3:0] m,
                             input logic [47:0] s, input bit retrig, input bit chain,
                             input logic [3:0] nm, input logic [47:0] ns, input bit long_mode);
        int d;
        if (!pre_trig) begin
            @(negedge clk);
            check({name, " idle tx_start"}, tx_start, 0);
            check({name, " idle busy"}, busy, 0);
            trig = 1'b1; mask = m; snap = s; txd = 1'b0;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            trig = 1'b0; mask = 4'($urandom); snap = {16'($urandom), $urandom};
            check($sformatf("%s byte%0d tx_start", name, i), tx_start, 1);
            check($sformatf("%s byte%0d data", name, i), data, exp_q[i]);
            check($sformatf("%s byte%0d busy", name, i), busy, 1);
            check($sformatf("%s byte%0d done", name, i), done, 0);
            txd = ($urandom_range(0, 3) == 0);
            d = pick_delay(long_mode);
            for (int j = 1; j <= d; j++) begin
                @(negedge clk);
                if (tx_start !== 1'b0 || data !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                    check($sformatf("%s byte%0d hold tx_start", name, i), tx_start, 0);
                    check($sformatf("%s byte%0d hold data", name, i), data, exp_q[i]);
                    check($sformatf("%s byte%0d hold busy", name, i), busy, 1);
                    check($sformatf("%s byte%0d hold done", name, i), done, 0);
                end else begin
                    n_checks++;
                end
                txd  = (j == d);
                trig = retrig && (i == 1) && (j == 1);
            end
        end
        @(negedge clk);
        txd = 1'b0; trig = 1'b0;
        check({name, " end done"}, done, 1);
        check({name, " end busy"}, busy, 0);
        check({name, " end tx_start"}, tx_start, 0);
        if (chain) begin
            trig = 1'b1; mask = nm; snap = ns;
        end
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, " quiet tx_start"}, tx_start, 0);
            check({name, " quiet busy"}, busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual still running, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [55:0] eb;
        logic [3:0]  rm;
        logic [47:0] rs;

        vt[0] = '{4'b0101, {12'hFFF, 12'h123, 12'h5E5, 12'hABC}, 9, 120'hA5_02_00_BC_0A_02_23_01_31};
        vt[1] = '{4'b0000, 48'h0123_4567_89AB, 3, 120'hA5_00_A5};
        vt[2] = '{4'b1111, {12'h07F, 12'h800, 12'hFFF, 12'h001}, 15,
                  120'hA5_04_00_01_00_01_FF_0F_02_00_08_03_7F_00_27};
        vt[3] = '{4'b1000, {12'h5A3, 12'hEEE, 12'hDDD, 12'hCCC}, 6, 120'hA5_01_03_A3_05_01};

        rst = 1'b1; trig = 1'b1; txd = 1'b0; sel = 1'b0; mask = 4'hF; snap = '1;
        repeat (3) @(negedge clk);
        check("reset a tx_start", a_tx_start, 0);
        check("reset a data", a_data, 0);
        check("reset a busy", a_busy, 0);
        check("reset a done", a_done, 0);
        check("reset b tx_start", b_tx_start, 0);
        check("reset b data", b_data, 0);
        check("reset b busy", b_busy, 0);
        check("reset b done", b_done, 0);
        rst = 1'b0; trig = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_frame($sformatf("vec%0d", i), 1'b0, vt[i].mask, vt[i].snap, i == 2, 1'b0,
                      4'h0, 48'h0, 1'b0);
            if (i == 2) idle_check("retrigger", 5);
        end

        // Back-to-back: new trigger in the o_done cycle
        load_vec(0);
        run_frame("chain1", 1'b0, vt[0].mask, vt[0].snap, 1'b0, 1'b1, vt[3].mask, vt[3].snap, 1'b0);
        load_vec(3);
        run_frame("chain2", 1'b1, 4'h0, 48'h0, 1'b0, 1'b0, 4'h0, 48'h0, 1'b0);

        // Reset mid-frame after the third byte starts
        @(negedge clk);
        trig = 1'b1; mask = vt[0].mask; snap = vt[0].snap;
        @(negedge clk); trig = 1'b0;
        check("abort byte0 data", data, 8'hA5);
        @(negedge clk); txd = 1'b1;
        @(negedge clk); txd = 1'b0;
        check("abort byte1 data", data, 8'h02);
        @(negedge clk); txd = 1'b1;
        @(negedge clk); txd = 1'b0;
        check("abort byte2 tx_start", tx_start, 1);
        check("abort byte2 data", data, 8'h00);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; txd = 1'b1;
        check("abort tx_start", tx_start, 0);
        check("abort data", data, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        @(negedge clk); txd = 1'b0;
        idle_check("abort stray", 6);

        // Single 32-bit channel without checksum
        sel = 1'b1;
        eb = 56'hA5_01_00_44_33_22_11;
        exp_q.delete();
        for (int j = 0; j < 7; j++) exp_q.push_back(eb[(6-j)*8 +: 8]);
        run_frame("b32", 1'b0, 4'b0001, 48'h0000_1122_3344, 1'b0, 1'b0, 4'h0, 48'h0, 1'b0);
        build_exp(1'b1, 4'b0000, 48'h0);
        run_frame("b_empty", 1'b0, 4'b0000, 48'h0, 1'b0, 1'b0, 4'h0, 48'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rs = {16'($urandom), $urandom};
            build_exp(1'b1, 4'b0001, rs);
            run_frame($sformatf("b_rand%0d", i), 1'b0, 4'b0001, rs, 1'b0, 1'b0, 4'h0, 48'h0, 1'b1);
        end
        @(negedge clk); sel = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rm = 4'($urandom);
            rs = {16'($urandom), $urandom};
            build_exp(1'b0, rm, rs);
            run_frame($sformatf("a_rand%0d", i), 1'b0, rm, rs, i == 3, 1'b0, 4'h0, 48'h0, 1'b1);
        end
        idle_check("final", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_frame_tx.md
DEBUG_FRAME_TX -- requirements
Module: debug_frame_tx

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of snapshot channels, legal range 1..255.
REQ-002 SHALL have parameter NB_CH, default 32: width of each channel in bits, minimum 1.
REQ-003 SHALL have parameter NB_DATA, default 8: UART byte width, fixed at 8.
REQ-004 SHALL have parameter SYNC, default 8'hA5: frame start byte.
REQ-005 SHALL have parameter CSUM_EN, default 1: 1 appends an XOR checksum byte, 0 omits it.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_trigger, input, 1 bit: request to capture and send one frame.
REQ-009 SHALL have port i_ch_mask, input, N_CH bits: bit k high selects channel k.
REQ-010 SHALL have port i_snapshot, input, N_CH*NB_CH bits: channel k occupies bits [k*NB_CH +: NB_CH].
REQ-011 SHALL have port i_txDone, input, 1 bit: UART byte-complete pulse.
REQ-012 SHALL have port o_tx_start, output, 1 bit: one-cycle UART start pulse.
REQ-013 SHALL have port o_data, output, NB_DATA bits: byte to transmit.
REQ-014 SHALL have port o_busy, output, 1 bit: high while a frame is in progress.
REQ-015 SHALL have port o_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-016 SHALL implement FSM states IDLE, SYNC, COUNT, CH_ID, CH_DATA, CSUM and WAIT_DONE.
REQ-017 SHALL, in IDLE on i_trigger, latch i_snapshot and i_ch_mask in that same cycle, then enter SYNC.
REQ-018 SHALL ignore i_trigger while o_busy is high; no queuing.
REQ-019 SHALL send frames in this order: SYNC; COUNT (popcount of the latched mask); for each selected channel in ascending index, one CH_ID byte (index k) followed by BPC = ceil(NB_CH/8) data bytes, LSB first, with pad bits zero; then CSUM if CSUM_EN=1.
REQ-020 SHALL, when the mask is all zero, send SYNC, COUNT=0x00, then CSUM (if enabled).
REQ-021 SHALL compute CSUM as the XOR of every preceding byte of the frame, SYNC included.
REQ-022 SHALL make the latency from trigger at cycle t to o_tx_start with o_data=SYNC exactly cycle t+1.
REQ-023 SHALL pulse o_tx_start for exactly one cycle per byte; o_data SHALL stay stable from that pulse until the matching i_txDone.
REQ-024 SHALL issue the next o_tx_start exactly one cycle after an accepted i_txDone.
REQ-025 SHALL ignore i_txDone when no byte is outstanding, including the cycle of o_tx_start itself.
REQ-026 SHALL set o_busy in the cycle after trigger acceptance and clear it together with the o_done pulse, which occurs the cycle after the last byte's i_txDone; the FSM returns to IDLE then.
REQ-027 SHALL skip unselected channels with no idle cycles between channel byte groups.
REQ-028 SHALL accept a new trigger in the cycle o_done is high; that frame's SYNC start follows one cycle later.

Reset
REQ-029 SHALL, on i_reset, enter IDLE with o_tx_start=0, o_data=0, o_busy=0, o_done=0, latched mask, snapshot and checksum cleared, and byte/channel counters at 0.
REQ-030 SHALL, on i_reset mid-frame, abort immediately, issue no further o_tx_start, and treat any later i_txDone as stray.
REQ-031 SHALL give i_reset priority over i_trigger in the same cycle.

Structure
REQ-032 SHALL place the FSM state encoding, the SYNC default and the BPC ceiling-division function in shared package debug_frame_pkg.
REQ-033 SHALL implement byte selection from the latched snapshot (channel, byte index) in one combinational sub-module, debug_byte_mux.
REQ-034 SHALL size counters with $clog2 of N_CH and BPC, minimum 1 bit each.

Verification
REQ-035 SHALL cover: N_CH=4, NB_CH=12, mask=0101, ch0=0xABC, ch2=0x123 -> bytes A5 02 00 BC 0A 02 23 01 31, then o_done.
REQ-036 SHALL cover: mask=0000, CSUM_EN=1 -> bytes A5 00 A5, o_busy high for exactly 3 byte periods.
REQ-037 SHALL cover: a second trigger during a frame -> only one frame sent, snapshot unchanged.
REQ-038 SHALL cover: i_reset asserted after the third byte's o_tx_start -> all outputs 0 next cycle; a later i_txDone produces no o_tx_start.
REQ-039 SHALL cover: CSUM_EN=0, N_CH=1, NB_CH=32, value 0x11223344 -> A5 01 00 44 33 22 11, no checksum.
REQ-040 SHALL cover: i_txDone delayed 1 to 1000 cycles at random -> o_data stable per REQ-023 and every o_tx_start exactly one cycle after its i_txDone.
